control_unit_pipe: RTL and testbench

- Pipelined successor to the single-cycle RV32I control unit. Decodes op/funct3/funct7 in Decode (D) and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Resolves all six RV32I branch conditions plus JAL/JALR in Execute (E), kills the wrong-path instruction itself, and flags illegal opcodes.
- Keeps a retired-instruction counter. Sits beside the datapath pipeline registers; the hazard unit drives flush_e_i.

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/ctrl_decoder.sv | 97 +++++++++
 rtl/control_unit_pipe.sv | 102 ++++++++++
 tb/tb_control_unit_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
//------------------------------------------------------------------------------
// ctrl_pkg : shared encodings and control bundle for the pipelined control unit
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    alu_op_e    alu_control;
    logic       alu_src;
    logic       alu_a_src;
    logic       pc_target_src;
    logic [2:0] funct3;
  } ctrl_bundle_t;

  // Flags come from rs1-rs2; carry=1 means no borrow, i.e. rs1 >= rs2 unsigned.
  function automatic logic branch_cond(input logic [2:0] f3, input logic z,
                                       input logic n, input logic c, input logic v);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n ^ v;
      3'b101:  return !(n ^ v);
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decoder.sv
//------------------------------------------------------------------------------
// ctrl_decoder : combinational D-stage decode of op/funct3/funct7 into a bundle
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7,
  output ctrl_bundle_t ctrl,
  output logic [2:0]   imm_src,
  output logic         illegal
);

  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic f7,
                                             input logic allow_sub);
    case (f3)
      3'b000:  return (allow_sub && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl        = '0;
    ctrl.valid  = 1'b1;
    ctrl.funct3 = funct3;
    imm_src     = IMM_I;
    illegal     = 1'b0;
    case (op)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_from_funct(funct3, funct7, 1'b1);
      end
      OP_I: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_from_funct(funct3, funct7, 1'b0);
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm_src          = IMM_B;
        illegal          = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write     = 1'b1;
        ctrl.jump          = 1'b1;
        ctrl.alu_src       = 1'b1;
        ctrl.pc_target_src = 1'b1;
        ctrl.result_src    = RES_PC4;
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_PASSB;
        imm_src          = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_a_src = 1'b1;
        imm_src        = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    // Unsupported encodings travel as an invalid bubble so they never write or retire.
    if (illegal) ctrl = '0;
  end

endmodule

`default_nettype wire

// File: rtl/control_unit_pipe.sv
//------------------------------------------------------------------------------
// control_unit_pipe : pipelined RV32I control with E-stage branch resolution
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_i,
  input  logic                  flush_e_i,
  input  logic                  zero_e_i,
  input  logic                  neg_e_i,
  input  logic                  carry_e_i,
  input  logic                  ovf_e_i,
  output logic [2:0]            imm_src_d_o,
  output logic                  illegal_d_o,
  output logic [ALU_CTRL_W-1:0] alu_control_e_o,
  output logic                  alu_src_e_o,
  output logic                  alu_a_src_e_o,
  output logic                  pcsrc_e_o,
  output logic                  pc_target_src_e_o,
  output logic                  mem_write_m_o,
  output logic                  reg_write_m_o,
  output logic [1:0]            result_src_m_o,
  output logic                  reg_write_w_o,
  output logic [1:0]            result_src_w_o,
  output logic [CNT_W-1:0]      retired_o
);

  ctrl_bundle_t     w_d;
  ctrl_bundle_t     r_e;
  logic             w_pcsrc;
  logic             r_m_valid;
  logic             r_m_reg_write;
  logic             r_m_mem_write;
  logic [1:0]       r_m_result_src;
  logic             r_w_valid;
  logic             r_w_reg_write;
  logic [1:0]       r_w_result_src;
  logic [CNT_W-1:0] r_retired;

  ctrl_decoder u_decoder (
    .op      (op_i),
    .funct3  (funct3_i),
    .funct7  (funct7_i),
    .ctrl    (w_d),
    .imm_src (imm_src_d_o),
    .illegal (illegal_d_o)
  );

  // Bubbles carry all-zero controls, so they can never redirect.
  assign w_pcsrc = r_e.jump |
                   (r_e.branch & branch_cond(r_e.funct3, zero_e_i, neg_e_i, carry_e_i, ovf_e_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_e            <= '0;
      r_m_valid      <= 1'b0;
      r_m_reg_write  <= 1'b0;
      r_m_mem_write  <= 1'b0;
      r_m_result_src <= 2'b00;
      r_w_valid      <= 1'b0;
      r_w_reg_write  <= 1'b0;
      r_w_result_src <= 2'b00;
      r_retired      <= '0;
    end else begin
      // A taken redirect kills the wrong-path instruction currently in D.
      r_e            <= (flush_e_i || w_pcsrc) ? '0 : w_d;
      r_m_valid      <= r_e.valid;
      r_m_reg_write  <= r_e.reg_write;
      r_m_mem_write  <= r_e.mem_write;
      r_m_result_src <= r_e.result_src;
      r_w_valid      <= r_m_valid;
      r_w_reg_write  <= r_m_reg_write;
      r_w_result_src <= r_m_result_src;
      if (r_w_valid) r_retired <= r_retired + 1'b1;
    end
  end

  assign alu_control_e_o   = ALU_CTRL_W'(r_e.alu_control);
  assign alu_src_e_o       = r_e.alu_src;
  assign alu_a_src_e_o     = r_e.alu_a_src;
  assign pcsrc_e_o         = w_pcsrc;
  assign pc_target_src_e_o = r_e.pc_target_src;
  assign mem_write_m_o     = r_m_mem_write;
  assign reg_write_m_o     = r_m_reg_write;
  assign result_src_m_o    = r_m_result_src;
  assign reg_write_w_o     = r_w_reg_write;
  assign result_src_w_o    = r_w_result_src;
  assign retired_o         = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_control_unit_pipe.sv
//------------------------------------------------------------------------------
// tb_control_unit_pipe : directed self-checking bench (counter width 4 for wrap)
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit_pipe;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [6:0]       op_i = 7'b0000000;
  logic [2:0]       funct3_i = 3'b000;
  logic             funct7_i = 1'b0;
  logic             flush_e_i = 1'b0;
  logic             zero_e_i = 1'b0;
  logic             neg_e_i = 1'b0;
  logic             carry_e_i = 1'b0;
  logic             ovf_e_i = 1'b0;
  logic [2:0]       imm_src_d_o;
  logic             illegal_d_o;
  logic [3:0]       alu_control_e_o;
  logic             alu_src_e_o;
  logic             alu_a_src_e_o;
  logic             pcsrc_e_o;
  logic             pc_target_src_e_o;
  logic             mem_write_m_o;
  logic             reg_write_m_o;
  logic [1:0]       result_src_m_o;
  logic             reg_write_w_o;
  logic [1:0]       result_src_w_o;
  logic [CNT_W-1:0] retired_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_unit_pipe #(.ALU_CTRL_W(4), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .op_i              (op_i),
    .funct3_i          (funct3_i),
    .funct7_i          (funct7_i),
    .flush_e_i         (flush_e_i),
    .zero_e_i          (zero_e_i),
    .neg_e_i           (neg_e_i),
    .carry_e_i         (carry_e_i),
    .ovf_e_i           (ovf_e_i),
    .imm_src_d_o       (imm_src_d_o),
    .illegal_d_o       (illegal_d_o),
    .alu_control_e_o   (alu_control_e_o),
    .alu_src_e_o       (alu_src_e_o),
    .alu_a_src_e_o     (alu_a_src_e_o),
    .pcsrc_e_o         (pcsrc_e_o),
    .pc_target_src_e_o (pc_target_src_e_o),
    .mem_write_m_o     (mem_write_m_o),
    .reg_write_m_o     (reg_write_m_o),
    .result_src_m_o    (result_src_m_o),
    .reg_write_w_o     (reg_write_w_o),
    .result_src_w_o    (result_src_w_o),
    .retired_o         (retired_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_i = op; funct3_i = f3; funct7_i = f7;
    #1;
  endtask

  // Opcode 0000000 is illegal, so idle cycles inject bubbles that never retire.
  task automatic idle();
    op_i = 7'b0000000; funct3_i = 3'b000; funct7_i = 1'b0;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    // Reset
    idle();
    repeat (2) tick();
    rst_i = 1'b0;
    chk("rst_alu_e", alu_control_e_o, 0);
    chk("rst_pcsrc", pcsrc_e_o, 0);
    chk("rst_regw_m", reg_write_m_o, 0);
    chk("rst_regw_w", reg_write_w_o, 0);
    chk("rst_retired", retired_o, 0);

    // R-type SUB through the pipe
    issue(7'b0110011, 3'b000, 1'b1);
    chk("sub_illegal", illegal_d_o, 0);
    tick(); idle();
    chk("sub_alu_e", alu_control_e_o, 4'b0001);
    chk("sub_alusrc_e", alu_src_e_o, 0);
    tick();
    chk("sub_regw_m", reg_write_m_o, 1);
    tick();
    chk("sub_regw_w", reg_write_w_o, 1);
    chk("sub_res_w", result_src_w_o, 0);
    tick();
    chk("sub_retired", retired_o, 1);
    chk("sub_regw_w_gone", reg_write_w_o, 0);

    // BLT taken (N=1,V=0) kills a following ADDI
    neg_e_i = 1'b1; ovf_e_i = 1'b0;
    issue(7'b1100011, 3'b100, 1'b0);
    chk("blt_imm_src", imm_src_d_o, 3'b001);
    tick();
    issue(7'b0010011, 3'b000, 1'b0);
    chk("blt_pcsrc", pcsrc_e_o, 1);
    chk("blt_alu_e", alu_control_e_o, 4'b0001);
    tick(); idle();
    chk("blt_kill_alu_e", alu_control_e_o, 0);
    chk("blt_kill_alusrc_e", alu_src_e_o, 0);
    chk("blt_kill_pcsrc", pcsrc_e_o, 0);
    tick();
    chk("blt_kill_regw_m", reg_write_m_o, 0);
    drain();
    chk("blt_retired", retired_o, 2);

    // BLT not taken (N=1,V=1)
    ovf_e_i = 1'b1;
    issue(7'b1100011, 3'b100, 1'b0);
    tick(); idle();
    chk("blt_nt_pcsrc", pcsrc_e_o, 0);
    neg_e_i = 1'b0; ovf_e_i = 1'b0;

    // BGEU then BLTU, toggling carry while each sits in E
    carry_e_i = 1'b1;
    issue(7'b1100011, 3'b111, 1'b0);
    tick(); idle();
    chk("bgeu_c1", pcsrc_e_o, 1);
    carry_e_i = 1'b0; #1;
    chk("bgeu_c0", pcsrc_e_o, 0);
    issue(7'b1100011, 3'b110, 1'b0);
    tick(); idle();
    chk("bltu_c0", pcsrc_e_o, 1);
    carry_e_i = 1'b1; #1;
    chk("bltu_c1", pcsrc_e_o, 0);

    // BEQ / BNE on zero flag
    zero_e_i = 1'b1;
    issue(7'b1100011, 3'b000, 1'b0);
    tick(); idle();
    chk("beq_z1", pcsrc_e_o, 1);
    zero_e_i = 1'b0; #1;
    chk("beq_z0", pcsrc_e_o, 0);
    issue(7'b1100011, 3'b001, 1'b0);
    tick(); idle();
    chk("bne_z0", pcsrc_e_o, 1);
    drain();
    chk("branch_retired", retired_o, 7);

    // JALR
    issue(7'b1100111, 3'b000, 1'b0);
    tick(); idle();
    chk("jalr_pcsrc", pcsrc_e_o, 1);
    chk("jalr_ptsrc", pc_target_src_e_o, 1);
    chk("jalr_alusrc", alu_src_e_o, 1);
    tick(); tick();
    chk("jalr_res_w", result_src_w_o, 2'b10);
    chk("jalr_regw_w", reg_write_w_o, 1);

    // Load followed by a load-use flush
    issue(7'b0000011, 3'b010, 1'b0);
    tick();
    issue(7'b0010011, 3'b000, 1'b0);
    flush_e_i = 1'b1;
    tick();
    flush_e_i = 1'b0; idle();
    chk("flush_alusrc_e", alu_src_e_o, 0);
    chk("load_regw_m", reg_write_m_o, 1);
    chk("load_res_m", result_src_m_o, 2'b01);
    tick();
    chk("load_res_w", result_src_w_o, 2'b01);
    chk("flush_regw_m", reg_write_m_o, 0);
    drain();
    chk("load_retired", retired_o, 9);

    // Illegal encodings
    issue(7'b1100011, 3'b010, 1'b0);
    chk("illegal_br_f3", illegal_d_o, 1);
    issue(7'b1111111, 3'b000, 1'b0);
    chk("illegal_op", illegal_d_o, 1);
    tick(); idle();
    chk("illegal_alusrc_e", alu_src_e_o, 0);
    tick();
    chk("illegal_regw_m", reg_write_m_o, 0);
    chk("illegal_memw_m", mem_write_m_o, 0);
    drain();
    chk("illegal_retired", retired_o, 9);

    // Store, LUI, AUIPC
    issue(7'b0100011, 3'b010, 1'b0);
    chk("store_imm", imm_src_d_o, 3'b010);
    tick();
    issue(7'b0110111, 3'b000, 1'b0);
    chk("lui_imm", imm_src_d_o, 3'b011);
    tick();
    issue(7'b0010111, 3'b000, 1'b0);
    chk("store_memw_m", mem_write_m_o, 1);
    chk("lui_alu_e", alu_control_e_o, 4'b1010);
    tick(); idle();
    chk("auipc_asrc_e", alu_a_src_e_o, 1);
    chk("auipc_alu_e", alu_control_e_o, 4'b0000);

    // Reset while a taken branch sits in E
    neg_e_i = 1'b1; ovf_e_i = 1'b0;
    issue(7'b1100011, 3'b100, 1'b0);
    tick(); idle();
    chk("rstbr_pcsrc_pre", pcsrc_e_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstbr_pcsrc", pcsrc_e_o, 0);
    chk("rstbr_regw_m", reg_write_m_o, 0);
    chk("rstbr_regw_w", reg_write_w_o, 0);
    chk("rstbr_retired", retired_o, 0);
    neg_e_i = 1'b0;

    // Counter wrap at 2^CNT_W
    issue(7'b0010011, 3'b000, 1'b0);
    repeat (15) tick();
    drain();
    chk("wrap_15", retired_o, 15);
    issue(7'b0010011, 3'b000, 1'b0);
    tick();
    drain();
    chk("wrap_0", retired_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
